// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with integrated baud prescaler.
// Optional line-break generation is enabled with `define UART_TX_BREAK_EN.
module uart_tx_cfg #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
`ifdef UART_TX_BREAK_EN
  input  logic                      BREAK_REQ,
`endif
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] PARITY   = 3'd3;
  localparam logic [2:0] STOP     = 3'd4;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] BRK      = 3'd5;
  localparam logic [2:0] BRK_TAIL = 3'd6;
`endif

  logic [2:0]                state;
  logic [PRESCALE_WIDTH-1:0] cnt;
  logic [PRESCALE_WIDTH-1:0] presc_sh;
  logic [DATA_WIDTH-1:0]     data_sh;
  logic [3:0]                bit_idx;
  logic                      stop_idx;
  logic                      par_en_sh;
  logic                      par_sh;
  logic                      stop2_sh;
  logic                      bit_end;

  assign bit_end = (cnt == presc_sh);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
      cnt       <= '0;
      presc_sh  <= '0;
      data_sh   <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      par_en_sh <= 1'b0;
      par_sh    <= 1'b0;
      stop2_sh  <= 1'b0;
    end else begin
      // Bit counter only runs while a frame is on the line.
      if (state == START || state == DATA || state == PARITY || state == STOP)
        cnt <= bit_end ? '0 : cnt + 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
`ifdef UART_TX_BREAK_EN
          if (BREAK_REQ) begin
            state  <= BRK;
            TX_OUT <= 1'b0;
            Busy   <= 1'b1;
          end else
`endif
          if (DATA_Valid && !Busy) begin
            data_sh   <= P_DATA;
            par_en_sh <= PAR_EN;
            par_sh    <= (^P_DATA) ^ PAR_TYP;
            stop2_sh  <= STOP2;
            presc_sh  <= PRESCALE;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            state     <= START;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
          end
        end
        START: if (bit_end) begin
          state  <= DATA;
          TX_OUT <= data_sh[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == 4'(DATA_WIDTH - 1)) begin
            bit_idx <= '0;
            if (par_en_sh) begin
              state  <= PARITY;
              TX_OUT <= par_sh;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
          end else begin
            // Shift so the next data bit always sits at index 1.
            bit_idx <= bit_idx + 1'b1;
            data_sh <= data_sh >> 1;
            TX_OUT  <= data_sh[1];
          end
        end
        PARITY: if (bit_end) begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (stop2_sh && !stop_idx) begin
            stop_idx <= 1'b1;
          end else begin
            stop_idx <= 1'b0;
            state    <= IDLE;
            Busy     <= 1'b0;
          end
        end
`ifdef UART_TX_BREAK_EN
        BRK: if (!BREAK_REQ) begin
          state  <= BRK_TAIL;
          TX_OUT <= 1'b1;
          cnt    <= '0;
        end
        // Trailing mark time uses the live PRESCALE, not a shadow copy.
        BRK_TAIL: begin
          if (cnt == PRESCALE) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
